// File: rtl/riscv_mdu.sv
// RV32M/RV64M iterative multiply/divide unit. It stalls the pipeline through mdu_busy and writes mdu_r/mdu_bubble for WB.
// Optional build macro RISCV_MDU_EARLY_OUT_EN: a multiply stops once the remaining multiplier bits are all zero.
module riscv_mdu #(
    parameter int XLEN     = 32,
    parameter int MUL_BITS = 2
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            ex_stall,
    input  logic            id_bubble,
    input  logic [XLEN-1:0] id_instr,
    input  logic [XLEN-1:0] opA,
    input  logic [XLEN-1:0] opB,
    input  logic [1:0]      st_xlen,
    output logic            mdu_busy,
    output logic            mdu_bubble,
    output logic [XLEN-1:0] mdu_r
);
    localparam logic [1:0] ST_RV32 = 2'b01;
    localparam int         PW      = 2 * XLEN;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;
    state_e state_q, state_d;

    // mplier doubles as the dividend/quotient shift register, mcand low half as the divisor
    logic [PW-1:0]   acc_q, acc_d, mcand_q, mcand_d;
    logic [XLEN-1:0] mplier_q, mplier_d, mdu_r_q, mdu_r_d;
    logic [XLEN:0]   rem_q, rem_d;
    logic [6:0]      cnt_q, cnt_d, last_q, last_d;
    logic [2:0]      f3_q, f3_d;
    logic            w32_q, w32_d, neg_q, neg_d, rneg_q, rneg_d, mdu_bubble_q, mdu_bubble_d;

    function automatic logic [XLEN-1:0] fit(input logic [XLEN-1:0] v, input logic w, input logic s);
        logic [XLEN-1:0] r;
        r = v;
        if (w) for (int i = 32; i < XLEN; i++) r[i] = s & v[31];
        return r;
    endfunction

    logic [2:0] f3;
    logic       is_op32, m_op, start, w_eff, is_div, sgn_a, sgn_b;
    assign f3      = id_instr[14:12];
    assign is_op32 = (id_instr[6:0] == 7'b0111011) && (XLEN == 64) && (st_xlen != ST_RV32)
                     && (f3 == 3'd0 || f3[2]);
    assign m_op    = ((id_instr[6:0] == 7'b0110011) || is_op32) && (id_instr[31:25] == 7'b0000001);
    assign start   = (state_q == IDLE) && !id_bubble && m_op && !ex_stall;
    assign w_eff   = is_op32 || (XLEN == 32) || (st_xlen == ST_RV32);
    assign is_div  = f3[2];
    assign sgn_a   = is_div ? !f3[0] : (f3 != 3'd3);
    assign sgn_b   = is_div ? !f3[0] : (f3 <= 3'd1);

    logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, fast_res;
    logic            a_neg, b_neg, div0, ovf, fast;
    always_comb begin
        a_ext    = fit(opA, w_eff, sgn_a);
        b_ext    = fit(opB, w_eff, sgn_b);
        a_neg    = sgn_a & a_ext[XLEN-1];
        b_neg    = sgn_b & b_ext[XLEN-1];
        a_mag    = a_neg ? -a_ext : a_ext;
        b_mag    = b_neg ? -b_ext : b_ext;
        div0     = (b_ext == '0);
        ovf      = sgn_b && (b_ext == '1) &&
                   (a_ext == (w_eff ? fit(XLEN'(32'h8000_0000), 1'b1, 1'b1) : {1'b1, {(XLEN-1){1'b0}}}));
        fast     = is_div && (div0 || ovf);
        fast_res = '0;
        if (div0)     fast_res = f3[1] ? fit(a_ext, w_eff, 1'b1) : '1;
        else if (ovf) fast_res = f3[1] ? '0 : fit(a_ext, w_eff, 1'b1);
    end

    // One iteration step of each engine, plus final sign fix and width selection
    logic [PW-1:0]   pp, acc_sum, prod, prod_hi;
    logic [XLEN-1:0] mpl_nx, quo_nx, quo_s, rem_s, mul_res, div_res;
    logic [XLEN:0]   rem_sh, trial, rem_nx;
    logic            mul_last;
    always_comb begin
        pp = '0;
        for (int k = 0; k < MUL_BITS; k++) if (mplier_q[k]) pp = pp + (mcand_q << k);
        acc_sum = acc_q + pp;
        mpl_nx  = mplier_q >> MUL_BITS;
        prod    = neg_q ? -acc_sum : acc_sum;
        prod_hi = prod >> (w32_q ? 32 : XLEN);
        mul_res = fit((f3_q == 3'd0) ? prod[XLEN-1:0] : prod_hi[XLEN-1:0], w32_q, 1'b1);
`ifdef RISCV_MDU_EARLY_OUT_EN
        mul_last = (cnt_q == last_q) || (mpl_nx == '0);
`else
        mul_last = (cnt_q == last_q);
`endif
        rem_sh  = {rem_q[XLEN-1:0], mplier_q[XLEN-1]};
        trial   = rem_sh - {1'b0, mcand_q[XLEN-1:0]};
        rem_nx  = trial[XLEN] ? rem_sh : trial;
        quo_nx  = {mplier_q[XLEN-2:0], !trial[XLEN]};
        quo_s   = neg_q ? -quo_nx : quo_nx;
        rem_s   = rneg_q ? -rem_nx[XLEN-1:0] : rem_nx[XLEN-1:0];
        div_res = fit(f3_q[1] ? rem_s : quo_s, w32_q, 1'b1);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = fast ? DONE : (is_div ? DIV : MUL);
            MUL:     if (mul_last) state_d = DONE;
            DIV:     if (cnt_q == last_q) state_d = DONE;
            default: if (!ex_stall) state_d = IDLE;
        endcase
    end

    always_comb begin
        mdu_busy = 1'b0;
        case (state_q)
            IDLE:     mdu_busy = start;
            MUL, DIV: mdu_busy = 1'b1;
            default:  mdu_busy = 1'b0;
        endcase
    end

    always_comb begin
        acc_d = acc_q; mcand_d = mcand_q; mplier_d = mplier_q; rem_d = rem_q;
        cnt_d = cnt_q; last_d = last_q; f3_d = f3_q; w32_d = w32_q;
        neg_d = neg_q; rneg_d = rneg_q; mdu_r_d = mdu_r_q; mdu_bubble_d = mdu_bubble_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    f3_d = f3; w32_d = w_eff; cnt_d = '0; acc_d = '0; rem_d = '0;
                    neg_d = a_neg ^ b_neg; rneg_d = a_neg;
                    if (is_div) begin
                        mplier_d = w_eff ? (a_mag << (XLEN - 32)) : a_mag;
                        mcand_d  = PW'(b_mag);
                        last_d   = 7'((w_eff ? 32 : XLEN) - 1);
                    end else begin
                        mplier_d = b_mag;
                        mcand_d  = PW'(a_mag);
                        last_d   = 7'((w_eff ? 32 : XLEN) / MUL_BITS - 1);
                    end
                    if (fast) begin
                        mdu_r_d = fast_res; mdu_bubble_d = 1'b0;
                    end
                end else if (!ex_stall) begin
                    mdu_bubble_d = 1'b1;
                end
            end
            MUL: begin
                acc_d = acc_sum; mcand_d = mcand_q << MUL_BITS; mplier_d = mpl_nx; cnt_d = cnt_q + 7'd1;
                if (mul_last) begin
                    mdu_r_d = mul_res; mdu_bubble_d = 1'b0;
                end
            end
            DIV: begin
                rem_d = rem_nx; mplier_d = quo_nx; cnt_d = cnt_q + 7'd1;
                if (cnt_q == last_q) begin
                    mdu_r_d = div_res; mdu_bubble_d = 1'b0;
                end
            end
            default: if (!ex_stall) mdu_bubble_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc_q <= '0; mcand_q <= '0; mplier_q <= '0; rem_q <= '0; cnt_q <= '0; last_q <= '0;
            f3_q <= '0; w32_q <= 1'b0; neg_q <= 1'b0; rneg_q <= 1'b0;
            mdu_r_q <= '0; mdu_bubble_q <= 1'b1;
        end else begin
            acc_q <= acc_d; mcand_q <= mcand_d; mplier_q <= mplier_d; rem_q <= rem_d;
            cnt_q <= cnt_d; last_q <= last_d; f3_q <= f3_d; w32_q <= w32_d;
            neg_q <= neg_d; rneg_q <= rneg_d; mdu_r_q <= mdu_r_d; mdu_bubble_q <= mdu_bubble_d;
        end
    end

    assign mdu_r      = mdu_r_q;
    assign mdu_bubble = mdu_bubble_q;

    logic unused_bits;
    assign unused_bits = ^{id_instr, rem_q[XLEN], prod_hi[PW-1:XLEN]};
endmodule
